// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU codes, state encodings and per-state control decode
// for the multicycle MIPS controller. JAL support: MULTICYCLE_CONTROL_JAL_EN.
package mips_ctrl_pkg;

  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] BNE    = 6'h05;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_ADDI  = 3'b100;
  localparam logic [2:0] ALU_ORI   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    EXEC_I   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL_ST   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       branchEq;
    logic       branchNe;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSource;
    logic [2:0] aluOp;
  } ctrl_t;

  // Control bundle for a state; op is the opcode owning that state.
  // FETCH pcWrite/irWrite are further qualified by mem_ready at the top.
  function automatic ctrl_t stateCtrl(
    input state_t     s,
    input logic [5:0] op
  );
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead  = 1'b1;
        c.iorD     = 1'b0;
        c.aluSrcA  = 1'b0;
        c.aluSrcB  = SRCB_FOUR;
        c.aluOp    = ALU_ADD;
        c.pcSource = PCSRC_ALU;
        c.irWrite  = 1'b1;
        c.pcWrite  = 1'b1;
      end
      DECODE: begin
        c.aluSrcA = 1'b0;
        c.aluSrcB = SRCB_IMM_SH2;
        c.aluOp   = ALU_ADD;
      end
      MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = ALU_ADD;
      end
      MEM_RD: begin
        c.memRead = 1'b1;
        c.iorD    = 1'b1;
      end
      MEM_WB: begin
        c.regWrite = 1'b1;
        c.memtoReg = 1'b1;
        c.regDst   = 1'b0;
      end
      MEM_WR: begin
        c.memWrite = 1'b1;
        c.iorD     = 1'b1;
      end
      EXEC_R: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_RT;
        c.aluOp   = ALU_RTYPE;
      end
      R_WB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      EXEC_I: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = SRCB_IMM;
        c.aluOp   = (op == ORI) ? ALU_ORI : ALU_ADDI;
      end
      I_WB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b0;
        c.memtoReg = 1'b0;
      end
      BRANCH: begin
        c.aluSrcA  = 1'b1;
        c.aluSrcB  = SRCB_RT;
        c.aluOp    = ALU_SUB;
        c.pcSource = PCSRC_ALUOUT;
        c.branchEq = (op == BEQ);
        c.branchNe = (op == BNE);
      end
      JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PCSRC_JUMP;
      end
`ifdef MULTICYCLE_CONTROL_JAL_EN
      JAL_ST: begin
        c.pcWrite  = 1'b1;
        c.pcSource = PCSRC_JUMP;
        c.regWrite = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter: sync active-low clear, increment enable,
// wraps modulo 2^W.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clrN,
  input  logic         en,
  output logic [W-1:0] count
);

  // Clear has priority over an increment on the same edge
  always_ff @(posedge clk) begin
    if (!clrN)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// Optional JAL (opcode 0x03) support: MULTICYCLE_CONTROL_JAL_EN.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OP,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               BranchEQ,
  output logic               BranchNE,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired,
  output logic [3:0]         state_dbg
);

  state_t     state;
  state_t     stateNext;
  logic [5:0] opQ;
  logic [5:0] opUse;
  ctrl_t      ctrlQ;
  logic       illegalQ;
  logic       illegalNext;
  logic       retire;
  logic       inFetch;

  // The opcode that owns the next state: live OP while decoding
  assign opUse = (state == DECODE) ? OP : opQ;

  // Next-state selection, retirement and illegal-opcode detection
  always_comb begin
    stateNext   = FETCH;
    retire      = 1'b0;
    illegalNext = 1'b0;
    case (state)
      FETCH:
        stateNext = mem_ready ? DECODE : FETCH;
      DECODE: begin
        unique case (1'b1)
          (OP == R_TYPE):
            stateNext = EXEC_R;
          (OP == ADDI),
          (OP == ORI):
            stateNext = EXEC_I;
          (OP == LW),
          (OP == SW):
            stateNext = MEM_ADDR;
          (OP == BEQ),
          (OP == BNE):
            stateNext = BRANCH;
          (OP == J):
            stateNext = JUMP;
`ifdef MULTICYCLE_CONTROL_JAL_EN
          (OP == JAL):
            stateNext = JAL_ST;
`else
          (OP == JAL):
            illegalNext = 1'b1;
`endif
          default:
            illegalNext = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        if (opQ == LW)
          stateNext = MEM_RD;
        else if (opQ == SW)
          stateNext = MEM_WR;
        else
          stateNext = FETCH;
      end
      MEM_RD:
        stateNext = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR: begin
        stateNext = mem_ready ? FETCH : MEM_WR;
        retire    = mem_ready;
      end
      EXEC_R:
        stateNext = R_WB;
      EXEC_I:
        stateNext = I_WB;
      MEM_WB, R_WB, I_WB, BRANCH, JUMP:
        retire = 1'b1;
`ifdef MULTICYCLE_CONTROL_JAL_EN
      JAL_ST:
        retire = 1'b1;
`endif
      default:
        stateNext = FETCH;
    endcase
  end

  // State, latched opcode, registered control bundle and illegal pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      opQ      <= '0;
      ctrlQ    <= stateCtrl(FETCH, 6'd0);
      illegalQ <= 1'b0;
    end else begin
      state    <= stateNext;
      if (state == DECODE)
        opQ <= OP;
      ctrlQ    <= stateCtrl(stateNext, opUse);
      illegalQ <= illegalNext;
    end
  end

  retire_counter #(
    .W (CNT_W)
  ) uRetire (
    .clk   (clk),
    .clrN  (reset),
    .en    (retire),
    .count (retired)
  );

  assign inFetch = (state == FETCH);

  // Strobes are held low for the whole time reset is asserted
  assign PCWrite    = reset & ctrlQ.pcWrite & (mem_ready | ~inFetch);
  assign IRWrite    = reset & ctrlQ.irWrite & mem_ready;
  assign BranchEQ   = reset & ctrlQ.branchEq;
  assign BranchNE   = reset & ctrlQ.branchNe;
  assign MemRead    = reset & ctrlQ.memRead;
  assign MemWrite   = reset & ctrlQ.memWrite;
  assign RegWrite   = reset & ctrlQ.regWrite;
  assign illegal_op = reset & illegalQ;

  assign IorD      = ctrlQ.iorD;
  assign MemtoReg  = ctrlQ.memtoReg;
  assign RegDst    = ctrlQ.regDst;
  assign ALUSrcA   = ctrlQ.aluSrcA;
  assign ALUSrcB   = ctrlQ.aluSrcB;
  assign PCSource  = ctrlQ.pcSource;
  assign ALUOp     = ALUOP_W'(ctrlQ.aluOp);
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed sequences,
// a table of per-instruction vectors and randomized instruction streams.
module tb_multicycle_control;

  localparam int CW = 4;
`ifdef MULTICYCLE_CONTROL_JAL_EN
  localparam bit JAL = 1'b1;
`else
  localparam bit JAL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    OP;
  logic          mem_ready;
  logic          PCWrite, BranchEQ, BranchNE, IorD;
  logic          MemRead, MemWrite, IRWrite;
  logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]    ALUSrcB, PCSource;
  logic [2:0]    ALUOp;
  logic          illegal_op;
  logic [CW-1:0] retired;
  logic [3:0]    state_dbg;

  multicycle_control #(.ALUOP_W(3), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .OP         (OP),
    .mem_ready  (mem_ready),
    .PCWrite    (PCWrite),
    .BranchEQ   (BranchEQ),
    .BranchNE   (BranchNE),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .MemtoReg   (MemtoReg),
    .RegDst     (RegDst),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSource   (PCSource),
    .ALUOp      (ALUOp),
    .illegal_op (illegal_op),
    .retired    (retired),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, beq, bne, iord, mrd, mwr, irw;
    logic       m2r, rdst, rwr, srcA;
    logic [1:0] srcB, pcs;
    logic [2:0] alu;
    logic       ill;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    int         ret;
    logic [6:0] seen;
  } vec_t;

  int   nChecks = 0;
  int   nFails  = 0;
  int   cnt     = 0;
  logic illPending = 1'b0;

  function automatic obs_t actual();
    return {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite,
            IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
            ALUSrcB, PCSource, ALUOp, illegal_op};
  endfunction

  function automatic logic [7:0] strobes();
    return {PCWrite, BranchEQ, BranchNE, MemRead,
            MemWrite, IRWrite, RegWrite, illegal_op};
  endfunction

  // Expected outputs of a phase; m marks the fields that are defined there
  function automatic void expOut(input int p, input logic [5:0] op,
      input logic mr, input logic ill, output obs_t e, output obs_t m);
    e = '0;
    m = '0;
    m.pcw = 1; m.beq = 1; m.bne = 1; m.mrd = 1;
    m.mwr = 1; m.irw = 1; m.rwr = 1; m.ill = 1;
    e.ill = ill;
    case (p)
      0: begin
        e.mrd = 1; e.irw = mr; e.pcw = mr;
        m.iord = 1; m.srcA = 1; m.srcB = '1; m.alu = '1; m.pcs = '1;
        e.srcB = 2'd1;
      end
      1: begin
        m.srcA = 1; m.srcB = '1; m.alu = '1;
        e.srcB = 2'd3;
      end
      2: begin
        m.srcA = 1; m.srcB = '1; m.alu = '1;
        e.srcA = 1; e.srcB = 2'd2;
      end
      3: begin
        e.mrd = 1; e.iord = 1; m.iord = 1;
      end
      4: begin
        e.rwr = 1; e.m2r = 1; m.m2r = 1; m.rdst = 1;
      end
      5: begin
        e.mwr = 1; e.iord = 1; m.iord = 1;
      end
      6: begin
        m.srcA = 1; m.srcB = '1; m.alu = '1;
        e.srcA = 1; e.alu = 3'b111;
      end
      7: begin
        e.rwr = 1; e.rdst = 1; m.rdst = 1;
      end
      8: begin
        m.srcA = 1; m.srcB = '1; m.alu = '1;
        e.srcA = 1; e.srcB = 2'd2;
        e.alu = (op == 6'h08) ? 3'b100 : 3'b101;
      end
      9: begin
        e.rwr = 1; m.rdst = 1; m.m2r = 1;
      end
      10: begin
        m.srcA = 1; m.srcB = '1; m.alu = '1; m.pcs = '1;
        e.srcA = 1; e.alu = 3'b001; e.pcs = 2'd1;
        e.beq = (op == 6'h04); e.bne = (op == 6'h05);
      end
      11: begin
        e.pcw = 1; e.pcs = 2'd2; m.pcs = '1;
      end
      12: begin
        e.pcw = 1; e.rwr = 1; e.pcs = 2'd2; m.pcs = '1;
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input int p, input logic mr, input logic [5:0] op);
    obs_t e, m, a;
    expOut(p, op, mr, illPending, e, m);
    illPending = 1'b0;
    a = actual();
    nChecks++;
    if (state_dbg !== 4'(p)) begin
      nFails++;
      $display("FAIL state: got %0d expected %0d", state_dbg, p);
    end
    nChecks++;
    if ((a & m) !== (e & m)) begin
      nFails++;
      $display("FAIL outputs st%0d op%0h: got %05h expected %05h",
               p, op, a & m, e & m);
    end
  endtask

  task automatic chkRetired(input string nm);
    nChecks++;
    if (retired !== CW'(cnt)) begin
      nFails++;
      $display("FAIL %s: retired got %0d expected %0d", nm, retired, cnt);
    end
  endtask

  // One cycle of a phase: drive, settle, check, advance to edge+1
  task automatic cyc(input int p, input logic mr, input logic [5:0] op);
    mem_ready = mr;
    OP = (p == 1) ? op : 6'($urandom_range(0, 63));
    #1;
    chk(p, mr, op);
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: phase list from the opcode, stalls on memory
  task automatic runInstr(input logic [5:0] op, input int sF, input int sM);
    int   ph[$];
    bit   legal;
    int   st;
    chkRetired("retired at fetch");
    ph = {0, 1};
    legal = 1;
    case (op)
      6'h00:        ph = {ph, 6, 7};
      6'h08, 6'h0D: ph = {ph, 8, 9};
      6'h23:        ph = {ph, 2, 3, 4};
      6'h2B:        ph = {ph, 2, 5};
      6'h04, 6'h05: ph = {ph, 10};
      6'h02:        ph = {ph, 11};
      6'h03:        if (JAL) ph = {ph, 12}; else legal = 0;
      default:      legal = 0;
    endcase
    foreach (ph[i]) begin
      if (ph[i] == 0 || ph[i] == 3 || ph[i] == 5) begin
        st = (ph[i] == 0) ? sF : sM;
        repeat (st) cyc(ph[i], 1'b0, op);
        cyc(ph[i], 1'b1, op);
      end else begin
        cyc(ph[i], 1'($urandom_range(0, 1)), op);
      end
    end
    if (legal) cnt = (cnt + 1) % (1 << CW);
    illPending = !legal;
  endtask

  function automatic logic [5:0] randLegal();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h08, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
    return ops[$urandom_range(0, 7)];
  endfunction

  vec_t       tbl [10];
  logic [6:0] seen;
  int         nCyc;

  initial begin
    tbl[0] = '{6'h00, 4, 1, 7'b1001011};
    tbl[1] = '{6'h08, 4, 1, 7'b1001011};
    tbl[2] = '{6'h0D, 4, 1, 7'b1001011};
    tbl[3] = '{6'h23, 5, 1, 7'b1001011};
    tbl[4] = '{6'h2B, 4, 1, 7'b1001110};
    tbl[5] = '{6'h04, 3, 1, 7'b1101010};
    tbl[6] = '{6'h05, 3, 1, 7'b1011010};
    tbl[7] = '{6'h3F, 2, 0, 7'b1001010};
    tbl[8] = JAL ? '{6'h03, 3, 1, 7'b1001011}
                 : '{6'h03, 2, 0, 7'b1001010};
    tbl[9] = '{6'h02, 3, 1, 7'b1001010};

    reset = 1'b0;
    mem_ready = 1'b1;
    OP = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (strobes() !== 8'h00) begin
      nFails++;
      $display("FAIL reset strobes: got %02h expected 00", strobes());
    end
    nChecks++;
    if (state_dbg !== 4'd0) begin
      nFails++;
      $display("FAIL reset state: got %0d expected 0", state_dbg);
    end
    chkRetired("reset retired");
    reset = 1'b1;

    runInstr(6'h00, 0, 0);
    runInstr(6'h23, 0, 3);
    runInstr(6'h05, 0, 0);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h03, 1, 0);
    runInstr(6'h2B, 2, 2);

    for (int t = 0; t < 10; t++) begin
      seen = '0;
      nCyc = 0;
      for (int k = 0; k < 20; k++) begin
        mem_ready = 1'b1;
        OP = tbl[t].op;
        #1;
        seen |= strobes()[7:1];
        nCyc++;
        @(posedge clk);
        #1;
        if (state_dbg == 4'd0) break;
      end
      cnt = (cnt + tbl[t].ret) % (1 << CW);
      nChecks++;
      if (nCyc != tbl[t].cycles) begin
        nFails++;
        $display("FAIL vec%0d cycles: got %0d expected %0d",
                 t, nCyc, tbl[t].cycles);
      end
      nChecks++;
      if (seen !== tbl[t].seen) begin
        nFails++;
        $display("FAIL vec%0d strobes: got %b expected %b",
                 t, seen, tbl[t].seen);
      end
      nChecks++;
      if (illegal_op !== (tbl[t].ret == 0)) begin
        nFails++;
        $display("FAIL vec%0d illegal: got %b expected %b",
                 t, illegal_op, tbl[t].ret == 0);
      end
      chkRetired("vec retired");
    end
    illPending = 1'b0;

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 4) == 0)
        runInstr(6'($urandom_range(0, 63)),
                 $urandom_range(0, 2), $urandom_range(0, 3));
      else
        runInstr(randLegal(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    chkRetired("before sw abort");
    cyc(0, 1'b1, 6'h2B);
    cyc(1, 1'b1, 6'h2B);
    cyc(2, 1'b1, 6'h2B);
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    nChecks++;
    if (MemWrite !== 1'b0 || strobes() !== 8'h00) begin
      nFails++;
      $display("FAIL abort strobes: got %02h expected 00", strobes());
    end
    @(posedge clk);
    #1;
    nChecks++;
    if (state_dbg !== 4'd0) begin
      nFails++;
      $display("FAIL abort state: got %0d expected 0", state_dbg);
    end
    cnt = 0;
    illPending = 1'b0;
    chkRetired("abort retired");
    reset = 1'b1;

    for (int n = 0; n < 17; n++)
      runInstr(randLegal(), $urandom_range(0, 1), $urandom_range(0, 2));
    nChecks++;
    if (retired !== 4'd1) begin
      nFails++;
      $display("FAIL wrap: retired got %0d expected 1", retired);
    end
    chkRetired("final retired");

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
